// File: rtl/fwd_haz_unit.sv
// Operand forwarding selects and pipeline stall control for a five-stage core,
// including a multi-cycle multiply unit tracked by a small IDLE/BUSY FSM.
module fwd_haz_unit #(
    parameter int NUM_SRC = 2,
    parameter int REG_AW  = 5,
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ip_ID_valid,
    input  logic [NUM_SRC*REG_AW-1:0] ip_ID_src,
    input  logic [NUM_SRC-1:0]        ip_ID_src_valid,
    input  logic                      ip_ID_mul_issue,
    input  logic [REG_AW-1:0]         ip_ID_dest,
    input  logic                      ip_ID_EX_MemRead,
    input  logic [REG_AW-1:0]         ip_ID_EX_dest,
    input  logic                      ip_EX_MEM_RegWrite,
    input  logic [REG_AW-1:0]         ip_EX_MEM_dest,
    input  logic                      ip_MEM_WB_RegWrite,
    input  logic [REG_AW-1:0]         ip_MEM_WB_dest,
    input  logic                      ip_cnt_clr,
    output logic [NUM_SRC*2-1:0]      op_fwd_sel,
    output logic                      op_stall,
    output logic                      op_mul_busy,
    output logic                      op_mul_done,
    output logic [CNT_W-1:0]          op_stall_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mul_state_e;

    localparam logic [3:0] MUL_LAT_C = 4'(MUL_LAT);

    mul_state_e          state_q;
    logic [3:0]          mul_cnt_q;
    logic [REG_AW-1:0]   mul_dest_q;
    logic [CNT_W-1:0]    stall_cnt_q;
    logic [CNT_W-1:0]    stall_cnt_d;

    logic [NUM_SRC*2-1:0] fwd_sel_s;
    logic                 src_ld_hit_s;
    logic                 src_mul_hit_s;
    logic                 mul_live_s;
    logic                 load_use_s;
    logic                 raw_s;
    logic                 struct_s;
    logic                 waw_s;
    logic                 stall_s;
    logic                 mul_accept_s;

    // Per-source forwarding selects and source-match flags for hazard detection
    always_comb begin
        fwd_sel_s     = '0;
        src_ld_hit_s  = 1'b0;
        src_mul_hit_s = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (ip_ID_src_valid[i] && (ip_ID_src[i*REG_AW +: REG_AW] != '0)) begin
                if (ip_EX_MEM_RegWrite && (ip_EX_MEM_dest == ip_ID_src[i*REG_AW +: REG_AW])) begin
                    fwd_sel_s[2*i +: 2] = 2'b10;
                end else if (ip_MEM_WB_RegWrite && (ip_MEM_WB_dest == ip_ID_src[i*REG_AW +: REG_AW])) begin
                    fwd_sel_s[2*i +: 2] = 2'b01;
                end else begin
                    fwd_sel_s[2*i +: 2] = 2'b00;
                end
                src_ld_hit_s  = src_ld_hit_s  | (ip_ID_src[i*REG_AW +: REG_AW] == ip_ID_EX_dest);
                src_mul_hit_s = src_mul_hit_s | (ip_ID_src[i*REG_AW +: REG_AW] == mul_dest_q);
            end else begin
                fwd_sel_s[2*i +: 2] = 2'b00;
            end
        end
    end

    // Reset masks the multiply status so an aborted multiply never reports done
    assign mul_live_s   = (state_q == BUSY) & ~rst;
    assign load_use_s   = ip_ID_valid & ip_ID_EX_MemRead & (ip_ID_EX_dest != '0) & src_ld_hit_s;
    assign raw_s        = mul_live_s & ip_ID_valid & (mul_dest_q != '0) & src_mul_hit_s;
    assign struct_s     = mul_live_s & ip_ID_valid & ip_ID_mul_issue;
    assign waw_s        = mul_live_s & ip_ID_valid & ~ip_ID_mul_issue & (mul_dest_q != '0)
                        & (ip_ID_dest == mul_dest_q);
    assign stall_s      = ~rst & (load_use_s | raw_s | struct_s | waw_s);
    assign mul_accept_s = ip_ID_valid & ip_ID_mul_issue & ~stall_s;

    assign op_fwd_sel   = fwd_sel_s;
    assign op_stall     = stall_s;
    assign op_mul_busy  = mul_live_s;
    assign op_mul_done  = mul_live_s & (mul_cnt_q == 4'd1);
    assign op_stall_cnt = stall_cnt_q;

    // Multiply occupancy FSM: count down MUL_LAT busy cycles per accepted multiply
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mul_cnt_q  <= 4'd0;
            mul_dest_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mul_accept_s) begin
                        state_q    <= BUSY;
                        mul_cnt_q  <= MUL_LAT_C;
                        mul_dest_q <= ip_ID_dest;
                    end else begin
                        state_q    <= IDLE;
                    end
                end
                BUSY: begin
                    if (mul_cnt_q == 4'd1) begin
                        state_q   <= IDLE;
                        mul_cnt_q <= 4'd0;
                    end else begin
                        mul_cnt_q <= mul_cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mul_cnt_q <= 4'd0;
                end
            endcase
        end
    end

    // Saturating stall counter; clear takes priority over a concurrent stall
    always_comb begin
        if (ip_cnt_clr) begin
            stall_cnt_d = '0;
        end else if (stall_s && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_fwd_haz_unit.sv
// Directed bench for fwd_haz_unit: a vector table for forwarding and load-use,
// then hand-written sequences for multiply timing, reset abort and counter saturation.
module tb_fwd_haz_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [9:0]  id_src;
    logic [1:0]  src_valid;
    logic        mul_issue;
    logic [4:0]  id_dest;
    logic        ex_memread;
    logic [4:0]  ex_dest;
    logic        em_rw;
    logic [4:0]  em_dest;
    logic        mw_rw;
    logic [4:0]  mw_dest;
    logic        cnt_clr;
    logic [3:0]  fwd_sel;
    logic        stall;
    logic        mul_busy;
    logic        mul_done;
    logic [3:0]  stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fwd_haz_unit #(.NUM_SRC(2), .REG_AW(5), .MUL_LAT(4), .CNT_W(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .ip_ID_valid       (id_valid),
        .ip_ID_src         (id_src),
        .ip_ID_src_valid   (src_valid),
        .ip_ID_mul_issue   (mul_issue),
        .ip_ID_dest        (id_dest),
        .ip_ID_EX_MemRead  (ex_memread),
        .ip_ID_EX_dest     (ex_dest),
        .ip_EX_MEM_RegWrite(em_rw),
        .ip_EX_MEM_dest    (em_dest),
        .ip_MEM_WB_RegWrite(mw_rw),
        .ip_MEM_WB_dest    (mw_dest),
        .ip_cnt_clr        (cnt_clr),
        .op_fwd_sel        (fwd_sel),
        .op_stall          (stall),
        .op_mul_busy       (mul_busy),
        .op_mul_done       (mul_done),
        .op_stall_cnt      (stall_cnt)
    );

    typedef struct {
        logic [9:0] src;
        logic [1:0] sv;
        logic       emrw;
        logic [4:0] emd;
        logic       mwrw;
        logic [4:0] mwd;
        logic       mr;
        logic [4:0] exd;
        logic       idv;
        logic [3:0] exp_sel;
        logic       exp_stall;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        id_valid   = 1'b0;
        id_src     = 10'd0;
        src_valid  = 2'b00;
        mul_issue  = 1'b0;
        id_dest    = 5'd0;
        ex_memread = 1'b0;
        ex_dest    = 5'd0;
        em_rw      = 1'b0;
        em_dest    = 5'd0;
        mw_rw      = 1'b0;
        mw_dest    = 5'd0;
        cnt_clr    = 1'b0;
    endtask

    // One decode cycle for the multiply sequences; checks stall/busy/done mid-cycle
    task automatic mc(input string nm, input logic v, input logic iss, input logic [4:0] d,
                      input logic [4:0] s0, input logic [1:0] sv,
                      input logic es, input logic eb, input logic ed);
        @(negedge clk);
        id_valid  = v;
        mul_issue = iss;
        id_dest   = d;
        id_src    = {5'd0, s0};
        src_valid = sv;
        #1;
        chk({nm, "_stall"}, 32'(stall), 32'(es));
        chk({nm, "_busy"},  32'(mul_busy), 32'(eb));
        chk({nm, "_done"},  32'(mul_done), 32'(ed));
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;

        // Reset state, with a load-use pattern present that must not stall under reset
        @(negedge clk);
        @(negedge clk);
        id_valid = 1'b1; ex_memread = 1'b1; ex_dest = 5'd7; id_src = {5'd7, 5'd0}; src_valid = 2'b10;
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_busy",  32'(mul_busy), 32'd0);
        chk("rst_done",  32'(mul_done), 32'd0);
        chk("rst_cnt",   32'(stall_cnt), 32'd0);
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;

        tbl[0]  = '{{5'd5, 5'd5}, 2'b11, 1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 4'b1010, 1'b0};
        tbl[1]  = '{{5'd5, 5'd5}, 2'b11, 1'b0, 5'd5, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 4'b0101, 1'b0};
        tbl[2]  = '{{5'd0, 5'd0}, 2'b11, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 4'b0000, 1'b0};
        tbl[3]  = '{{5'd4, 5'd3}, 2'b11, 1'b1, 5'd3, 1'b1, 5'd4, 1'b0, 5'd0, 1'b1, 4'b0110, 1'b0};
        tbl[4]  = '{{5'd4, 5'd3}, 2'b01, 1'b1, 5'd3, 1'b1, 5'd4, 1'b0, 5'd0, 1'b1, 4'b0010, 1'b0};
        tbl[5]  = '{{5'd4, 5'd3}, 2'b11, 1'b0, 5'd3, 1'b1, 5'd3, 1'b0, 5'd0, 1'b1, 4'b0001, 1'b0};
        tbl[6]  = '{{5'd7, 5'd0}, 2'b10, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b1, 4'b0000, 1'b1};
        tbl[7]  = '{{5'd7, 5'd0}, 2'b01, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b1, 4'b0000, 1'b0};
        tbl[8]  = '{{5'd0, 5'd0}, 2'b11, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 4'b0000, 1'b0};
        tbl[9]  = '{{5'd7, 5'd0}, 2'b10, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 4'b0000, 1'b0};
        tbl[10] = '{{5'd1, 5'd7}, 2'b01, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b1, 4'b0000, 1'b1};
        tbl[11] = '{{5'd6, 5'd6}, 2'b11, 1'b1, 5'd6, 1'b0, 5'd0, 1'b1, 5'd6, 1'b1, 4'b1010, 1'b1};

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            id_src = tbl[i].src; src_valid = tbl[i].sv;
            em_rw = tbl[i].emrw; em_dest = tbl[i].emd;
            mw_rw = tbl[i].mwrw; mw_dest = tbl[i].mwd;
            ex_memread = tbl[i].mr; ex_dest = tbl[i].exd; id_valid = tbl[i].idv;
            cnt_clr = 1'b1;
            #1;
            chk($sformatf("vec%0d_sel", i), 32'(fwd_sel), 32'(tbl[i].exp_sel));
            chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(tbl[i].exp_stall));
        end

        // Load-use stall lasts exactly one cycle and counts once
        @(negedge clk);
        idle_inputs();
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        #1;
        chk("lu_cnt0", 32'(stall_cnt), 32'd0);
        id_valid = 1'b1; ex_memread = 1'b1; ex_dest = 5'd7; id_src = {5'd7, 5'd2}; src_valid = 2'b11;
        #1;
        chk("lu_stall", 32'(stall), 32'd1);
        @(negedge clk);
        ex_memread = 1'b0; ex_dest = 5'd0;
        #1;
        chk("lu_release", 32'(stall), 32'd0);
        chk("lu_cnt1", 32'(stall_cnt), 32'd1);
        ex_memread = 1'b1; ex_dest = 5'd7; src_valid = 2'b01;
        #1;
        chk("lu_srcinv", 32'(stall), 32'd0);
        @(negedge clk);
        #1;
        chk("lu_cnt_hold", 32'(stall_cnt), 32'd1);
        idle_inputs();

        // Multiply to r9, dependent reader stalls cycles 1-4 and proceeds at 5
        mc("a0", 1'b1, 1'b1, 5'd9, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 4; c++)
            mc($sformatf("a%0d", c), 1'b1, 1'b0, 5'd0, 5'd9, 2'b01, 1'b1, 1'b1, c == 4);
        mc("a5", 1'b1, 1'b0, 5'd0, 5'd9, 2'b01, 1'b0, 1'b0, 1'b0);

        // Back-to-back multiplies: second is held until the unit is idle again
        mc("b0", 1'b1, 1'b1, 5'd9, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 4; c++)
            mc($sformatf("b%0d", c), 1'b1, 1'b1, 5'd11, 5'd0, 2'b00, 1'b1, 1'b1, c == 4);
        mc("b5", 1'b1, 1'b1, 5'd11, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
        for (int c = 6; c <= 9; c++)
            mc($sformatf("b%0d", c), 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, c == 9);
        mc("b10", 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);

        // WAW stall, then reset in the second busy cycle aborts without a done pulse
        mc("c0", 1'b1, 1'b1, 5'd9, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
        mc("c1_waw", 1'b1, 1'b0, 5'd9, 5'd0, 2'b00, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        mc("c2_rst", 1'b1, 1'b0, 5'd12, 5'd9, 2'b01, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int c = 3; c <= 6; c++)
            mc($sformatf("c%0d", c), 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
        chk("c_cnt_after_rst", 32'(stall_cnt), 32'd0);

        // Held load-use stall saturates the 4-bit counter; clear wins over stall
        @(negedge clk);
        idle_inputs();
        id_valid = 1'b1; ex_memread = 1'b1; ex_dest = 5'd3; id_src = {5'd0, 5'd3}; src_valid = 2'b01;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("sat%0d", k), 32'(stall_cnt), (k > 15) ? 32'd15 : 32'(k));
        end
        cnt_clr = 1'b1;
        #1;
        chk("clr_stall_active", 32'(stall), 32'd1);
        @(negedge clk);
        #1;
        chk("clr_wins", 32'(stall_cnt), 32'd0);
        idle_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
